wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writers: the pipeline MEM/WB stage and the multi-cycle execution unit (MUL/DIV) result bus.
- WB has absolute priority. Multi-cycle results wait in a 2-entry buffer until the port is idle.
- A starvation counter requests a one-bubble WB stall when needed.
- Exports pending-destination match flags so decode can stall reads of registers with undrained results.

---
 rtl/cpu_pipe_pkg.sv | 22 ++
 rtl/wbq_fifo2.sv | 75 +++++++
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the register-file write-port arbiter and its result buffer.
package cpu_pipe_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t XZR_IDX     = 5'd31;
  localparam int       WBQ_DATA_W  = 64;

  // Data is stored at the widest supported width; narrower builds use the low bits.
  typedef struct packed {
    logic                  valid;
    reg_idx_t              rd;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    STARVE = 2'd2
  } wbarb_state_t;

endpackage

// File: rtl/wbq_fifo2.sv
// Two-entry result FIFO with kill-by-destination and pending-source match outputs.
module wbq_fifo2
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [4:0]        push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [4:0]        kill_rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  output logic              head_valid,
  output logic [4:0]        head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              hit1,
  output logic              hit2
);

  wbq_entry_t slot_reg [2];
  logic       head_reg;
  logic       tail_reg;
  logic [1:0] count_reg;
  logic [1:0] hit1_vec;
  logic [1:0] hit2_vec;
  wbq_entry_t head_ent;

  // A slot being written this edge is never killed; popped slots drop valid so stale matches cannot occur.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push && tail_reg == 1'(i)) begin
          slot_reg[i].valid <= 1'b1;
          slot_reg[i].rd    <= push_rd;
          slot_reg[i].data  <= WBQ_DATA_W'(push_data);
        end else if (pop && head_reg == 1'(i)) begin
          slot_reg[i].valid <= 1'b0;
        end else if (kill_en && slot_reg[i].valid && slot_reg[i].rd == kill_rd) begin
          slot_reg[i].valid <= 1'b0;
        end
      end
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign hit1_vec[gi] = slot_reg[gi].valid && (slot_reg[gi].rd == rn);
      assign hit2_vec[gi] = slot_reg[gi].valid && (slot_reg[gi].rd == rm);
    end
  endgenerate

  assign hit1 = (|hit1_vec) && (rn != XZR_IDX);
  assign hit2 = (|hit2_vec) && (rm != XZR_IDX);

  assign head_ent   = slot_reg[head_reg];
  assign head_valid = head_ent.valid && (count_reg != 2'd0);
  assign head_rd    = head_ent.rd;
  assign head_data  = DATA_W'(head_ent.data);
  assign count      = count_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB has priority, MUL/DIV results drain from a 2-entry buffer.
// Optional macro WB_ARB_STATS_EN enables the 16-bit stall-cycle statistics counter.
module wb_port_arbiter
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [4:0]        mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              stall_req,
  output logic [15:0]       stat_stall_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wbarb_state_t      state_reg, state_next;
  logic              ready_en_reg;
  logic [3:0]        starve_cnt_reg;
  logic              wb_hold;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        count;
  logic [1:0]        count_next;

  assign wb_hold    = wb_we && (wb_rd != XZR_IDX);
  assign mc_ready   = ready_en_reg && (count != 2'd2);
  // Results to XZR are acknowledged but dropped.
  assign push       = mc_valid && mc_ready && (mc_rd != XZR_IDX);
  assign pop        = !wb_hold && (count != 2'd0);
  assign count_next = count + 2'(push) - 2'(pop);

  wbq_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_rd    (mc_rd),
    .push_data  (mc_data),
    .pop        (pop),
    .kill_en    (wb_hold),
    .kill_rd    (wb_rd),
    .rn         (rn),
    .rm         (rm),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count),
    .hit1       (pend_hit1),
    .hit2       (pend_hit2)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (wb_hold) begin
      rf_we = 1'b1;
      rf_wa = wb_rd;
      rf_wd = wb_data;
    end else if (pop && head_valid) begin
      rf_we = 1'b1;
      rf_wa = head_rd;
      rf_wd = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_reg   <= 1'b0;
      starve_cnt_reg <= 4'd0;
      state_reg      <= IDLE;
    end else begin
      ready_en_reg <= 1'b1;
      state_reg    <= state_next;
      if (pop)
        starve_cnt_reg <= 4'd0;
      else if (head_valid && wb_hold && starve_cnt_reg < LIMIT)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_next != 2'd0) state_next = PEND;
      PEND: begin
        if (count_next == 2'd0)
          state_next = IDLE;
        else if (!pop && starve_cnt_reg == LIMIT)
          state_next = STARVE;
      end
      STARVE:  if (pop) state_next = (count_next == 2'd0) ? IDLE : PEND;
      default: state_next = IDLE;
    endcase
  end

  assign stall_req = (state_reg == STARVE);

`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stat_cnt_reg <= 16'd0;
    else if (stall_req && stat_cnt_reg != 16'hFFFF)
      stat_cnt_reg <= stat_cnt_reg + 16'd1;
  end

  assign stat_stall_cnt = stat_cnt_reg;
`else
  assign stat_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DW  = 64;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          mc_valid = 1'b0;
  logic          mc_ready;
  logic [4:0]    mc_rd = '0;
  logic [DW-1:0] mc_data = '0;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [DW-1:0] rf_wd;
  logic [4:0]    rn = '0;
  logic [4:0]    rm = '0;
  logic          pend_hit1, pend_hit2, stall_req;
  logic [15:0]   stat_stall_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rn(rn), .rm(rm), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .stall_req(stall_req), .stat_stall_cnt(stat_stall_cnt)
  );

  typedef struct {
    bit          valid;
    int          rd;
    logic [63:0] data;
  } ment_t;

  ment_t       q[$];
  bit          m_ready_en;
  bit          m_stall;
  int          m_starve;
  int          m_stat;
  logic [63:0] dut_rf [32];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_stat();
`ifdef WB_ARB_STATS_EN
    return m_stat;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit we, input int wrd, input logic [63:0] wd,
                      input bit mv, input int mrd, input logic [63:0] md,
                      input int a, input int b);
    bit          hold, e_ready, popq, e_we, h1, h2, head_live, old_stall;
    int          e_wa, old_starve;
    logic [63:0] e_wd;
    @(negedge clk);
    wb_we = we; wb_rd = 5'(wrd); wb_data = wd;
    mc_valid = mv; mc_rd = 5'(mrd); mc_data = md;
    rn = 5'(a); rm = 5'(b);
    #1;
    hold    = we && wrd != 31;
    e_ready = m_ready_en && q.size() < 2;
    popq    = !hold && q.size() > 0;
    e_we = 0; e_wa = 0; e_wd = '0;
    if (hold) begin
      e_we = 1; e_wa = wrd; e_wd = wd;
    end else if (popq && q[0].valid) begin
      e_we = 1; e_wa = q[0].rd; e_wd = q[0].data;
    end
    h1 = 0; h2 = 0;
    foreach (q[i]) begin
      if (q[i].valid && q[i].rd == a && a != 31) h1 = 1;
      if (q[i].valid && q[i].rd == b && b != 31) h2 = 1;
    end
    check("rf_we", rf_we, e_we);
    check("rf_wa", rf_wa, e_wa);
    check("rf_wd", rf_wd, e_wd);
    check("mc_ready", mc_ready, e_ready);
    check("pend_hit1", pend_hit1, h1);
    check("pend_hit2", pend_hit2, h2);
    check("stall_req", stall_req, m_stall);
    check("stat_cnt", stat_stall_cnt, exp_stat());
    if (rf_we) begin
      dut_rf[rf_wa] = rf_wd;
      $display("t=%0t write x%0d = %0h", $time, rf_wa, rf_wd);
    end
    head_live  = q.size() > 0 && q[0].valid;
    old_starve = m_starve;
    old_stall  = m_stall;
    if (popq) void'(q.pop_front());
    if (hold) foreach (q[i]) if (q[i].rd == wrd) q[i].valid = 0;
    if (mv && e_ready && mrd != 31) q.push_back('{1'b1, mrd, md});
    if (popq) m_starve = 0;
    else if (head_live && hold && m_starve < LIM) m_starve++;
    if (popq) m_stall = 0;
    else if (old_starve == LIM) m_stall = 1;
    if (old_stall && m_stat < 65535) m_stat++;
    m_ready_en = 1;
  endtask

  task automatic do_reset(input int a);
    @(negedge clk);
    reset_n = 0; wb_we = 0; mc_valid = 0; rn = 5'(a); rm = 5'(a);
    #1;
    check("rst_mc_ready", mc_ready, 0);
    check("rst_stall_req", stall_req, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_pend_hit1", pend_hit1, 0);
    check("rst_stat", stat_stall_cnt, 0);
    q.delete(); m_stall = 0; m_starve = 0; m_stat = 0; m_ready_en = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    m_ready_en = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    do_reset(0);

    // Single result with WB idle.
    step(0, 0, 0, 1, 5, 64'hAA, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    check("dir_x5", dut_rf[5], 64'hAA);

    // WB busy every cycle: buffer fills, starvation stall, then drains.
    step(1, 10, 64'h10, 1, 3, 64'h33, 3, 4);
    step(1, 11, 64'h11, 1, 4, 64'h44, 3, 4);
    for (int k = 0; k < 4; k++) step(1, 12 + k, 64'h12 + k, 1, 6, 64'h66, 3, 4);
    step(0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 0, 0, 0, 0, 0, 3, 4);
    check("dir_x3", dut_rf[3], 64'h33);

    // WAW kill of a buffered result.
    step(1, 1, 64'h1, 1, 7, 64'h77, 7, 0);
    step(1, 7, 64'h7007, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    check("dir_x7", dut_rf[7], 64'h7007);

    // XZR result is acknowledged and dropped.
    step(0, 0, 0, 1, 31, 64'hDEAD, 31, 31);
    step(0, 0, 0, 0, 0, 0, 31, 31);
    step(0, 0, 0, 0, 0, 0, 31, 31);

    // Long starvation to accumulate stall cycles.
    step(1, 9, 64'h9, 1, 8, 64'h88, 8, 9);
    for (int k = 0; k < 15; k++) step(1, 9, 64'h900 + k, 0, 0, 0, 8, 9);
    step(0, 0, 0, 0, 0, 0, 8, 9);
    step(0, 0, 0, 0, 0, 0, 8, 9);

    // Reset with two entries buffered.
    step(1, 20, 64'h20, 1, 2, 64'h22, 2, 6);
    step(1, 21, 64'h21, 1, 6, 64'h66, 2, 6);
    do_reset(2);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 2, 6);

    // Randomized traffic over a small register range to provoke kills and hits.
    for (int k = 0; k < 400; k++) begin
      int wrd, mrd;
      wrd = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
      mrd = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 60), wrd, {$urandom, $urandom},
           ($urandom_range(0, 99) < 50), mrd, {$urandom, $urandom},
           int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7)));
      if (k == 200) do_reset(int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
